// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush sequencer: prefix stall merge, exception vs. mispredict arbitration, redirect PC.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl #(
   parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
   parameter int unsigned FLUSH_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_id_i,
   input  logic        req_ex_i,
   input  logic        req_mem_i,
   input  logic        req_wb_i,
   input  logic        exc_valid_i,
   input  logic        exc_eret_i,
   input  logic [31:0] epc_i,
   input  logic        mispred_i,
   input  logic [31:0] mispred_pc_i,
   output logic [3:0]  stall_o,
   output logic        flush_o,
   output logic        flush_cause_o,
   output logic [31:0] new_pc_o,
   input  logic        perf_sel_i,
   output logic [31:0] perf_cnt_o
);

   typedef enum logic [1:0] {IDLE, EXC_WAIT, BR_WAIT, FLUSH} state_t;

   localparam logic [2:0] CNT_INIT = 3'(FLUSH_CYCLES - 1);

   state_t      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic        flush_q, flush_d;
   logic        cause_q, cause_d;
   logic [31:0] pc_q, pc_d;
   logic        eret_q, eret_d;
   logic [31:0] epc_q, epc_d;
   logic [31:0] brpc_q, brpc_d;
   logic [3:0]  live_stall;
   logic [3:0]  stall;
   logic        flush_event;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         flush_q <= 1'b0;
         cause_q <= 1'b0;
         pc_q    <= '0;
         eret_q  <= 1'b0;
         epc_q   <= '0;
         brpc_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         flush_q <= flush_d;
         cause_q <= cause_d;
         pc_q    <= pc_d;
         eret_q  <= eret_d;
         epc_q   <= epc_d;
         brpc_q  <= brpc_d;
      end
   end

   // Output logic: the oldest stalling stage holds itself and everything younger.
   always_comb begin
      if (req_wb_i)       live_stall = 4'b1111;
      else if (req_mem_i) live_stall = 4'b0111;
      else if (req_ex_i)  live_stall = 4'b0011;
      else if (req_id_i)  live_stall = 4'b0001;
      else                live_stall = 4'b0000;

      stall = live_stall;
      if (state_q == EXC_WAIT) stall = stall | 4'b0111;
      if (flush_q)             stall = 4'b0000;
   end

   assign stall_o       = stall;
   assign flush_o       = flush_q;
   assign flush_cause_o = cause_q;
   assign new_pc_o      = pc_q;

   // Next-state logic
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      flush_d     = flush_q;
      cause_d     = cause_q;
      pc_d        = pc_q;
      eret_d      = eret_q;
      epc_d       = epc_q;
      brpc_d      = brpc_q;
      flush_event = 1'b0;

      case (state_q)
         IDLE, BR_WAIT: begin
            // A new exception always beats a live or parked mispredict.
            if (exc_valid_i) begin
               if (!req_mem_i) begin
                  flush_event = 1'b1;
                  cause_d     = 1'b1;
                  pc_d        = exc_eret_i ? epc_i : EXC_VECTOR;
               end else begin
                  state_d = EXC_WAIT;
                  eret_d  = exc_eret_i;
                  epc_d   = epc_i;
               end
            end else if (state_q == BR_WAIT) begin
               if (!stall[1]) begin
                  flush_event = 1'b1;
                  cause_d     = 1'b0;
                  pc_d        = brpc_q;
               end
            end else if (mispred_i) begin
               if (!stall[1]) begin
                  flush_event = 1'b1;
                  cause_d     = 1'b0;
                  pc_d        = mispred_pc_i;
               end else begin
                  state_d = BR_WAIT;
                  brpc_d  = mispred_pc_i;
               end
            end
         end
         EXC_WAIT: begin
            if (!req_mem_i) begin
               flush_event = 1'b1;
               cause_d     = 1'b1;
               pc_d        = eret_q ? epc_q : EXC_VECTOR;
            end
         end
         FLUSH: begin
            if (cnt_q == 3'd0) begin
               state_d = IDLE;
               flush_d = 1'b0;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (flush_event) begin
         state_d = FLUSH;
         flush_d = 1'b1;
         cnt_d   = CNT_INIT;
      end
   end

`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] flush_cnt_q, flush_cnt_d;
   logic [31:0] perf_q, perf_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q + 32'(stall != 4'b0000);
      flush_cnt_d = flush_cnt_q + 32'(flush_event);
      perf_d      = perf_sel_i ? flush_cnt_q : stall_cnt_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
         perf_q      <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
         perf_q      <= perf_d;
      end
   end

   assign perf_cnt_o = perf_q;
`else
   logic [1:0] unused_perf;
   assign unused_perf = {perf_sel_i, flush_event};
   assign perf_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed vector table, reset/perf sequences, and random stimulus against
// a rule-level model. Two instances (FLUSH_CYCLES=1 and 3) share the same inputs.
module tb_pipe_ctrl;

   localparam logic [31:0] VEC = 32'hBFC0_0380;
`ifdef PIPE_CTRL_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   typedef struct {
      logic        id, ex, mem, wb, exc, eret, mis, sel, rst;
      logic [31:0] epc, mpc;
   } in_t;

   typedef struct {
      in_t         in;
      logic [3:0]  st;
      logic        fl;
      logic        ca;
      logic [31:0] pc;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_id = 1'b0, req_ex = 1'b0, req_mem = 1'b0, req_wb = 1'b0;
   logic        exc_valid = 1'b0, exc_eret = 1'b0, mispred = 1'b0, perf_sel = 1'b0;
   logic [31:0] epc = '0, mispred_pc = '0;
   logic [3:0]  stall_w [2];
   logic        flush_w [2];
   logic        cause_w [2];
   logic [31:0] pc_w    [2];
   logic [31:0] perf_w  [2];

   int n_chk  = 0;
   int n_fail = 0;

   in_t  iv;
   vec_t tbl[$];

   // Model state, one slot per instance
   int          fl_left  [2];
   logic        m_cause  [2];
   logic [31:0] m_pc     [2];
   logic        exc_pend [2];
   logic [31:0] exc_tgt  [2];
   logic        br_pend  [2];
   logic [31:0] br_tgt   [2];
   logic [31:0] scnt     [2];
   logic [31:0] fcnt     [2];
   logic [31:0] perf_exp [2];

   always #5 clk = ~clk;

   pipe_ctrl #(.FLUSH_CYCLES(1)) u0 (
      .clk(clk), .rst(rst), .req_id_i(req_id), .req_ex_i(req_ex), .req_mem_i(req_mem),
      .req_wb_i(req_wb), .exc_valid_i(exc_valid), .exc_eret_i(exc_eret), .epc_i(epc),
      .mispred_i(mispred), .mispred_pc_i(mispred_pc), .stall_o(stall_w[0]), .flush_o(flush_w[0]),
      .flush_cause_o(cause_w[0]), .new_pc_o(pc_w[0]), .perf_sel_i(perf_sel), .perf_cnt_o(perf_w[0])
   );

   pipe_ctrl #(.FLUSH_CYCLES(3)) u1 (
      .clk(clk), .rst(rst), .req_id_i(req_id), .req_ex_i(req_ex), .req_mem_i(req_mem),
      .req_wb_i(req_wb), .exc_valid_i(exc_valid), .exc_eret_i(exc_eret), .epc_i(epc),
      .mispred_i(mispred), .mispred_pc_i(mispred_pc), .stall_o(stall_w[1]), .flush_o(flush_w[1]),
      .flush_cause_o(cause_w[1]), .new_pc_o(pc_w[1]), .perf_sel_i(perf_sel), .perf_cnt_o(perf_w[1])
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Inputs change on the falling edge; outputs are sampled 1 time unit later.
   task automatic drive(input in_t v);
      @(negedge clk);
      req_id = v.id; req_ex = v.ex; req_mem = v.mem; req_wb = v.wb;
      exc_valid = v.exc; exc_eret = v.eret; epc = v.epc;
      mispred = v.mis; mispred_pc = v.mpc; perf_sel = v.sel; rst = v.rst;
      #1;
   endtask

   task automatic idle();
      iv = '{default: '0};
   endtask

   // b = {id, ex, mem, wb, exc, eret, mis}
   task automatic add(input logic [6:0] b, input logic [31:0] e, input logic [31:0] m,
                      input logic [3:0] st, input logic fl, input logic ca, input logic [31:0] pc);
      vec_t v;
      v.in = '{default: '0};
      v.in.id = b[6]; v.in.ex = b[5]; v.in.mem = b[4]; v.in.wb = b[3];
      v.in.exc = b[2]; v.in.eret = b[1]; v.in.mis = b[0];
      v.in.epc = e; v.in.mpc = m;
      v.st = st; v.fl = fl; v.ca = ca; v.pc = pc;
      tbl.push_back(v);
   endtask

   task automatic model_reset(input int k);
      fl_left[k] = 0; m_cause[k] = 1'b0; m_pc[k] = '0;
      exc_pend[k] = 1'b0; exc_tgt[k] = '0; br_pend[k] = 1'b0; br_tgt[k] = '0;
      scnt[k] = '0; fcnt[k] = '0; perf_exp[k] = '0;
   endtask

   task automatic start_flush(input int k, input int fc, input logic ca, input logic [31:0] pc);
      fl_left[k] = fc; m_cause[k] = ca; m_pc[k] = pc;
      exc_pend[k] = 1'b0; br_pend[k] = 1'b0;
      fcnt[k] = fcnt[k] + 1;
   endtask

   // Expected outputs come from the pipeline rules: deepest stalling stage sets the prefix length,
   // a parked exception holds ID..MEM, and a flush in progress masks everything.
   task automatic model_cycle(input int k);
      int          d, fc;
      logic [3:0]  st;
      logic [31:0] tgt, nperf;
      fc = (k == 0) ? 1 : 3;
      d  = iv.wb ? 4 : iv.mem ? 3 : iv.ex ? 2 : iv.id ? 1 : 0;
      st = 4'((1 << d) - 1);
      if (exc_pend[k]) st = st | 4'b0111;
      if (fl_left[k] > 0) st = 4'b0000;

      chk($sformatf("rnd_stall%0d", k), 32'(stall_w[k]), 32'(st));
      chk($sformatf("rnd_flush%0d", k), 32'(flush_w[k]), 32'(fl_left[k] > 0));
      if (fl_left[k] > 0) begin
         chk($sformatf("rnd_cause%0d", k), 32'(cause_w[k]), 32'(m_cause[k]));
         chk($sformatf("rnd_pc%0d", k), pc_w[k], m_pc[k]);
      end
      chk($sformatf("rnd_perf%0d", k), perf_w[k], perf_exp[k]);

      nperf = PERF ? (iv.sel ? fcnt[k] : scnt[k]) : 32'd0;
      perf_exp[k] = nperf;
      if (st != 4'b0000) scnt[k] = scnt[k] + 1;

      if (iv.rst) begin
         model_reset(k);
      end else if (fl_left[k] > 0) begin
         fl_left[k] = fl_left[k] - 1;
      end else if (exc_pend[k]) begin
         if (!iv.mem) start_flush(k, fc, 1'b1, exc_tgt[k]);
      end else if (iv.exc) begin
         tgt = iv.eret ? iv.epc : VEC;
         br_pend[k] = 1'b0;
         if (iv.mem) begin
            exc_pend[k] = 1'b1;
            exc_tgt[k]  = tgt;
         end else begin
            start_flush(k, fc, 1'b1, tgt);
         end
      end else if (br_pend[k]) begin
         if (!st[1]) start_flush(k, fc, 1'b0, br_tgt[k]);
      end else if (iv.mis) begin
         if (!st[1]) start_flush(k, fc, 1'b0, iv.mpc);
         else begin
            br_pend[k] = 1'b1;
            br_tgt[k]  = iv.mpc;
         end
      end
   endtask

   initial begin
      // Directed vectors for instance 0 (single-cycle flush)
      for (int i = 0; i < 3; i++) add(7'b0100000, 0, 0, 4'b0011, 0, 0, 0);
      add(7'b0000000, 0, 0, 4'b0000, 0, 0, 0);
      add(7'b0000100, 0, 0, 4'b0000, 0, 0, 0);
      add(7'b0000000, 0, 0, 4'b0000, 1, 1, VEC);
      add(7'b0000000, 0, 0, 4'b0000, 0, 0, 0);
      add(7'b0010110, 32'h1234_5678, 0, 4'b0111, 0, 0, 0);
      for (int i = 0; i < 4; i++) add(7'b0010000, 32'hDEAD_BEEF, 0, 4'b0111, 0, 0, 0);
      add(7'b0000000, 0, 0, 4'b0111, 0, 0, 0);
      add(7'b0000000, 0, 0, 4'b0000, 1, 1, 32'h1234_5678);
      add(7'b0000000, 0, 0, 4'b0000, 0, 0, 0);
      add(7'b0000111, 32'h8000_1000, 32'hBFC0_0040, 4'b0000, 0, 0, 0);
      add(7'b0000000, 0, 0, 4'b0000, 1, 1, 32'h8000_1000);
      add(7'b0000000, 0, 0, 4'b0000, 0, 0, 0);
      add(7'b0100001, 0, 32'hBFC0_0040, 4'b0011, 0, 0, 0);
      add(7'b0100000, 0, 0, 4'b0011, 0, 0, 0);
      add(7'b0100000, 0, 0, 4'b0011, 0, 0, 0);
      add(7'b0000000, 0, 0, 4'b0000, 0, 0, 0);
      add(7'b0000000, 0, 0, 4'b0000, 1, 0, 32'hBFC0_0040);
      add(7'b0000000, 0, 0, 4'b0000, 0, 0, 0);
      add(7'b1000001, 0, 32'h0000_4000, 4'b0001, 0, 0, 0);
      add(7'b0001000, 0, 0, 4'b0000, 1, 0, 32'h0000_4000);
      add(7'b0001000, 0, 0, 4'b1111, 0, 0, 0);
      add(7'b0110000, 0, 0, 4'b0111, 0, 0, 0);
      add(7'b0000000, 0, 0, 4'b0000, 0, 0, 0);
      add(7'b0100001, 0, 32'h1111_0000, 4'b0011, 0, 0, 0);
      add(7'b0100100, 0, 0, 4'b0011, 0, 0, 0);
      add(7'b0000000, 0, 0, 4'b0000, 1, 1, VEC);
      add(7'b0000000, 0, 0, 4'b0000, 0, 0, 0);
      add(7'b0000000, 0, 0, 4'b0000, 0, 0, 0);

      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("rst_stall%0d", k), 32'(stall_w[k]), 32'd0);
         chk($sformatf("rst_flush%0d", k), 32'(flush_w[k]), 32'd0);
         chk($sformatf("rst_cause%0d", k), 32'(cause_w[k]), 32'd0);
         chk($sformatf("rst_pc%0d", k), pc_w[k], 32'd0);
         chk($sformatf("rst_perf%0d", k), perf_w[k], 32'd0);
      end

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].in);
         chk($sformatf("vec%0d_stall", i), 32'(stall_w[0]), 32'(tbl[i].st));
         chk($sformatf("vec%0d_flush", i), 32'(flush_w[0]), 32'(tbl[i].fl));
         if (tbl[i].fl) begin
            chk($sformatf("vec%0d_cause", i), 32'(cause_w[0]), 32'(tbl[i].ca));
            chk($sformatf("vec%0d_pc", i), pc_w[0], tbl[i].pc);
         end
      end

      // Reset during FLUSH leaves no residual flush on either instance.
      idle(); iv.exc = 1'b1; drive(iv);
      idle(); iv.rst = 1'b1; drive(iv);
      chk("rstflush_pre0", 32'(flush_w[0]), 32'd1);
      chk("rstflush_pre1", 32'(flush_w[1]), 32'd1);
      idle(); drive(iv);
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("rstflush_flush%0d", k), 32'(flush_w[k]), 32'd0);
         chk($sformatf("rstflush_pc%0d", k), pc_w[k], 32'd0);
         chk($sformatf("rstflush_cause%0d", k), 32'(cause_w[k]), 32'd0);
      end
      drive(iv);
      chk("rstflush_late1", 32'(flush_w[1]), 32'd0);

      // Reset while an exception waits on the dcache discards it.
      idle(); iv.exc = 1'b1; iv.mem = 1'b1; drive(iv);
      idle(); iv.mem = 1'b1; iv.rst = 1'b1; drive(iv);
      chk("rstwait_stall", 32'(stall_w[0]), 32'h7);
      idle(); drive(iv);
      chk("rstwait_stall_after", 32'(stall_w[0]), 32'd0);
      drive(iv);
      chk("rstwait_noflush0", 32'(flush_w[0]), 32'd0);
      chk("rstwait_noflush1", 32'(flush_w[1]), 32'd0);

      // Performance counters: 10 stall cycles and 2 flush events.
      idle(); iv.rst = 1'b1; drive(iv);
      idle(); iv.ex = 1'b1;
      repeat (10) drive(iv);
      for (int f = 0; f < 2; f++) begin
         idle(); iv.exc = 1'b1; drive(iv);
         idle(); repeat (4) drive(iv);
      end
      idle(); iv.sel = 1'b0; drive(iv);
      iv.sel = 1'b1; drive(iv);
      chk("perf_stall0", perf_w[0], PERF ? 32'd10 : 32'd0);
      chk("perf_stall1", perf_w[1], PERF ? 32'd10 : 32'd0);
      iv.sel = 1'b0; drive(iv);
      chk("perf_flush0", perf_w[0], PERF ? 32'd2 : 32'd0);
      chk("perf_flush1", perf_w[1], PERF ? 32'd2 : 32'd0);

      // Random traffic against the model
      idle(); iv.rst = 1'b1; drive(iv);
      model_reset(0);
      model_reset(1);
      for (int i = 0; i < 3000; i++) begin
         iv.id   = ($urandom_range(3) == 0);
         iv.ex   = ($urandom_range(3) == 0);
         iv.mem  = ($urandom_range(3) == 0);
         iv.wb   = ($urandom_range(5) == 0);
         iv.exc  = ($urandom_range(9) == 0);
         iv.eret = ($urandom_range(1) == 0);
         iv.mis  = ($urandom_range(5) == 0);
         iv.sel  = ($urandom_range(1) == 0);
         iv.rst  = ($urandom_range(299) == 0);
         iv.epc  = $urandom;
         iv.mpc  = $urandom;
         drive(iv);
         model_cycle(0);
         model_cycle(1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
